// File: rtl/mem_arb.sv
// Unified word-organised memory shared by NUM_PORTS valid/ready requesters, one access per cycle.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module mem_arb #(
  parameter int unsigned WD_SIZE     = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned NUM_PORTS   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [WD_SIZE*DEPTH_WORDS-1:0]   input_data,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*WD_SIZE-1:0]     req_addr,
  input  logic [NUM_PORTS*WD_SIZE-1:0]     req_wdata,
  input  logic [NUM_PORTS*(WD_SIZE/8)-1:0] req_be,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS*WD_SIZE-1:0]     resp_rdata,
  output logic [NUM_PORTS-1:0]             resp_err
);

  localparam int unsigned BE_W  = WD_SIZE / 8;
  localparam int unsigned OFS   = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned HI_SH = OFS + IDX_W;

  logic [WD_SIZE-1:0] mem [DEPTH_WORDS];

  logic [PTR_W-1:0]     ptr;
  logic [NUM_PORTS-1:0] gnt;
  logic [PTR_W-1:0]     gidx;
  logic [PTR_W-1:0]     cand;
  logic                 found;
  int unsigned          sidx;
  logic                 any_gnt;

  logic                 sel_wr;
  logic [WD_SIZE-1:0]   sel_addr;
  logic [WD_SIZE-1:0]   sel_wdata;
  logic [BE_W-1:0]      sel_be;
  logic [IDX_W-1:0]     word;
  logic                 out_range;

  // Grant search starting at ptr, wrapping modulo NUM_PORTS; nothing granted in reset
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    sidx  = 0;
    if (reset_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        sidx = int'(ptr) + i;
        if (sidx >= NUM_PORTS) sidx = sidx - NUM_PORTS;
        cand = PTR_W'(sidx);
        if (!found && req_valid[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gidx      = cand;
        end
      end
    end
  end

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  assign sel_wr    = req_wr[gidx];
  assign sel_addr  = req_addr[int'(gidx)*WD_SIZE +: WD_SIZE];
  assign sel_wdata = req_wdata[int'(gidx)*WD_SIZE +: WD_SIZE];
  assign sel_be    = req_be[int'(gidx)*BE_W +: BE_W];
  assign word      = IDX_W'(sel_addr >> OFS);
  assign out_range = |(sel_addr >> HI_SH);

`ifdef MEM_ARB_RR_EN
  // Pointer moves just past the last granted port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Array: preload image while in reset, byte-masked writes otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < DEPTH_WORDS; k++) begin
        mem[k] <= input_data[k*WD_SIZE +: WD_SIZE];
      end
    end else if (any_gnt && sel_wr && !out_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // One-cycle response on the granted port; idle ports return to zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= '0;
    end else begin
      resp_valid <= gnt;
      resp_rdata <= '0;
      resp_err   <= '0;
      if (any_gnt) begin
        if (out_range) begin
          resp_err[gidx] <= 1'b1;
        end else if (!sel_wr) begin
          resp_rdata[int'(gidx)*WD_SIZE +: WD_SIZE] <= mem[word];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb at default parameters.
// Arbitration expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arb;

  localparam int unsigned WD = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned NP = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WD*DW-1:0] input_data;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_wr;
  logic [NP*WD-1:0] req_addr;
  logic [NP*WD-1:0] req_wdata;
  logic [NP*4-1:0]  req_be;
  logic [NP-1:0]    resp_valid;
  logic [NP*WD-1:0] resp_rdata;
  logic [NP-1:0]    resp_err;

  logic [WD-1:0] model [DW];
  int n_cmp  = 0;
  int n_fail = 0;

  mem_arb #(.WD_SIZE(WD), .DEPTH_WORDS(DW), .NUM_PORTS(NP)) dut (
    .clk(clk), .reset_n(reset_n), .input_data(input_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WD-1:0] pre(input int k);
    if (k == 3) return 32'hDEADBEEF;
    if (k == 5) return 32'hAAAAAAAA;
    return 32'h5A00_0000 ^ (32'(k) * 32'h0001_0101);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic drive(input int p, input logic wr, input logic [WD-1:0] addr,
                       input logic [WD-1:0] wdata, input logic [3:0] be);
    idle();
    req_valid[p]        = 1'b1;
    req_wr[p]           = wr;
    req_addr[p*WD +: WD]  = addr;
    req_wdata[p*WD +: WD] = wdata;
    req_be[p*4 +: 4]      = be;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    for (int k = 0; k < DW; k++) model[k] = pre(k);
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got %b want 00", req_ready);
    end
    cycle();
    cycle();
    n_cmp++;
    if (resp_valid !== 2'b00 || resp_rdata !== '0 || resp_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_outputs got v=%b d=%h e=%b want 0", resp_valid, resp_rdata, resp_err);
    end
    idle();
    reset_n = 1'b1;
    for (int k = 0; k < DW; k++) model[k] = pre(k);
  endtask

  task automatic test_read_preload();
    drive(0, 1'b0, 32'h0C, '0, 4'h0);
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL read_ready got %b want 01", req_ready);
    end
    cycle();
    idle();
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_rdata[31:0] !== 32'hDEADBEEF || resp_err !== 2'b00) begin
      n_fail++; $display("FAIL read_preload got v=%b d=%h e=%b want 01 deadbeef 00", resp_valid, resp_rdata[31:0], resp_err);
    end
    n_cmp++;
    if (resp_rdata[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL read_other_port got %h want 0", resp_rdata[63:32]);
    end
    cycle();
    n_cmp++;
    if (resp_valid !== 2'b00 || resp_rdata !== '0) begin
      n_fail++; $display("FAIL resp_return_zero got v=%b d=%h want 0", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_unaligned();
    drive(0, 1'b0, 32'h0E, '0, 4'h0);
    cycle();
    idle();
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_rdata[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL unaligned got v=%b d=%h want 01 deadbeef", resp_valid, resp_rdata[31:0]);
    end
  endtask

  task automatic test_byte_enable();
    drive(1, 1'b1, 32'h14, 32'h11223344, 4'b0101);
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL write_ready got %b want 10", req_ready);
    end
    cycle();
    model[5] = 32'hAA22AA44;
    drive(1, 1'b0, 32'h14, '0, 4'h0);
    n_cmp++;
    if (resp_valid !== 2'b10 || resp_rdata !== '0 || resp_err !== 2'b00) begin
      n_fail++; $display("FAIL write_ack got v=%b d=%h e=%b want 10 0 00", resp_valid, resp_rdata, resp_err);
    end
    cycle();
    idle();
    n_cmp++;
    if (resp_valid !== 2'b10 || resp_rdata[63:32] !== 32'hAA22AA44) begin
      n_fail++; $display("FAIL byte_enable got v=%b d=%h want 10 aa22aa44", resp_valid, resp_rdata[63:32]);
    end
  endtask

  task automatic test_out_of_range();
    drive(1, 1'b0, 32'h100, '0, 4'h0);
    cycle();
    drive(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
    n_cmp++;
    if (resp_valid !== 2'b10 || resp_err !== 2'b10 || resp_rdata !== '0) begin
      n_fail++; $display("FAIL oor_read got v=%b e=%b d=%h want 10 10 0", resp_valid, resp_err, resp_rdata);
    end
    cycle();
    idle();
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_err !== 2'b01 || resp_rdata !== '0) begin
      n_fail++; $display("FAIL oor_write got v=%b e=%b d=%h want 01 01 0", resp_valid, resp_err, resp_rdata);
    end
    cycle();
    n_cmp++;
    if (resp_err !== 2'b00) begin
      n_fail++; $display("FAIL err_return_zero got %b want 00", resp_err);
    end
    for (int k = 0; k < DW; k++) begin
      drive(0, 1'b0, 32'(k * 4), '0, 4'h0);
      cycle();
      n_cmp++;
      if (resp_valid !== 2'b01 || resp_rdata[31:0] !== model[k]) begin
        n_fail++; $display("FAIL array_word%0d got v=%b d=%h want 01 %h", k, resp_valid, resp_rdata[31:0], model[k]);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_arbitration();
    logic [NP-1:0] want [4];
    logic [NP-1:0] seen;
`ifdef MEM_ARB_RR_EN
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
`else
    want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b01; want[3] = 2'b01;
`endif
    do_reset();
    idle();
    req_valid = 2'b11;
    req_addr  = {32'h14, 32'h0C};
    for (int c = 0; c < 4; c++) begin
      #1;
      seen = req_ready;
      n_cmp++;
      if (seen !== want[c]) begin
        n_fail++; $display("FAIL arb_grant%0d got %b want %b", c, seen, want[c]);
      end
      cycle();
      n_cmp++;
      if (resp_valid !== want[c] ||
          (want[c][0] && resp_rdata[31:0] !== model[3]) ||
          (want[c][1] && resp_rdata[63:32] !== model[5])) begin
        n_fail++; $display("FAIL arb_resp%0d got v=%b d=%h want v=%b", c, resp_valid, resp_rdata, want[c]);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_reset_mid();
    drive(1, 1'b1, 32'h0C, 32'h55555555, 4'hF);
    cycle();
    idle();
    reset_n = 1'b0;
    req_valid = 2'b10;
    req_wr    = 2'b10;
    req_addr  = {32'h0C, 32'h0};
    req_wdata = {32'h66666666, 32'h0};
    req_be    = 8'hF0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL midreset_ready got %b want 00", req_ready);
    end
    cycle();
    n_cmp++;
    if (resp_valid !== 2'b00 || resp_rdata !== '0 || resp_err !== 2'b00) begin
      n_fail++; $display("FAIL midreset_resp got v=%b d=%h e=%b want 0", resp_valid, resp_rdata, resp_err);
    end
    cycle();
    idle();
    reset_n = 1'b1;
    for (int k = 0; k < DW; k++) model[k] = pre(k);
    for (int k = 0; k < DW; k++) begin
      drive(1, 1'b0, 32'(k * 4), '0, 4'h0);
      cycle();
      n_cmp++;
      if (resp_valid !== 2'b10 || resp_rdata[63:32] !== model[k]) begin
        n_fail++; $display("FAIL midreset_word%0d got v=%b d=%h want 10 %h", k, resp_valid, resp_rdata[63:32], model[k]);
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    for (int k = 0; k < DW; k++) input_data[k*WD +: WD] = pre(k);
    idle();
    reset_n = 1'b0;
    test_reset();
    test_read_preload();
    test_unaligned();
    test_byte_enable();
    test_out_of_range();
    test_arbitration();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-bank, word-organised data/instruction memory shared by `NUM_PORTS` requesters through a valid/ready request channel and a fixed-latency response channel. It replaces the two independent `memory` instances in the processor top with one unified array: fetch and data access become channels of this block, arbitrated one access per cycle. It keeps the preload-during-reset behaviour and adds byte enables, range checking and fair arbitration.

## Interface
- `WD_SIZE`, 32: word width in bits; multiple of 8.
- `DEPTH_WORDS`, 64: number of words; power of two, ≥ 2.
- `NUM_PORTS`, 2: requester channels; 1..8. Port 0 is fetch, port 1 is data.

Ports (per-port buses are flattened, port i occupies slice i):
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `input_data` in `WD_SIZE*DEPTH_WORDS`: preload image; word k = bits `[k*WD_SIZE +: WD_SIZE]`.
- `req_valid` in `NUM_PORTS`: request present.
- `req_ready` out `NUM_PORTS`: request accepted this cycle when high together with `req_valid`.
- `req_wr` in `NUM_PORTS`: 1 = write, 0 = read.
- `req_addr` in `NUM_PORTS*WD_SIZE`: byte address.
- `req_wdata` in `NUM_PORTS*WD_SIZE`: write data.
- `req_be` in `NUM_PORTS*(WD_SIZE/8)`: byte enables for writes; ignored on reads.
- `resp_valid` out `NUM_PORTS`: response for that port this cycle.
- `resp_rdata` out `NUM_PORTS*WD_SIZE`: read data.
- `resp_err` out `NUM_PORTS`: access was out of range.

## Operation
- Address split: `OFS = log2(WD_SIZE/8)` low bits ignored (word-aligned access); next `log2(DEPTH_WORDS)` bits = word index; any remaining upper bit set → out of range.
- Arbitration each cycle: among ports with `req_valid`, exactly one gets `req_ready`=1; all others 0. `req_ready` is combinational from `req_valid` and the priority pointer; a port with `req_valid`=0 never sees `req_ready`=1.
- Priority pointer `ptr` (log2 NUM_PORTS bits): search starts at `ptr`, wraps modulo `NUM_PORTS`. After a grant to port g, `ptr` ← (g+1) mod `NUM_PORTS`; with no grant `ptr` holds.
- In-range write: bytes with `req_be` bit set are updated; others keep value. `resp_rdata` = 0.
- In-range read: `resp_rdata` = array word as it was before this cycle's edge.
- Out-of-range: array untouched, `resp_rdata` = 0, `resp_err` = 1.
- Every accepted request (read or write) gets exactly one response on its own port; write responses are acknowledgements.
- Requesters hold `req_*` stable while `req_valid`=1 and `req_ready`=0; the block does not buffer unaccepted requests.

## Timing
- Reset (`reset_n`=0 at an edge): array ← `input_data`, `ptr` ← 0, `resp_valid` ← 0, `resp_rdata` ← 0, `resp_err` ← 0; `req_ready` forced to 0 while `reset_n`=0.
- Reset mid-operation: a response due next cycle is dropped; no write in that cycle takes effect (preload wins).
- Latency: accepted at edge N → `resp_valid`/data/err valid for exactly one cycle after edge N, sampled at edge N+1. No response backpressure.
- Throughput: one access per cycle total across all ports.
- Write at edge N followed by read of same word accepted at edge N+1 returns the new data.
- `resp_valid` is one-hot or zero; between responses, `resp_rdata` and `resp_err` of a port return to 0.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin pointer as described.
- Undefined: fixed priority, lowest requesting index wins every cycle; `ptr` logic absent (implementation holds it at 0). All other behaviour identical.

## Test plan
- Preload word 3 = 0xDEADBEEF, hold reset 2 cycles, port 0 reads addr 0x0C → next cycle `resp_valid[0]`=1, `resp_rdata` = 0xDEADBEEF, `resp_err`=0.
- Port 1 writes 0x11223344 with `req_be`=4'b0101 to a word preloaded 0xAAAAAAAA, then reads it → 0xAA22AA44.
- Both ports hold `req_valid` for 4 cycles, `MEM_ARB_RR_EN` defined → grants 0,1,0,1; undefined → grants 0,0,0,0 with port 1 stalled.
- Read addr `DEPTH_WORDS*4` (0x100 for defaults) → `resp_err`=1, `resp_rdata`=0; write to 0x100 leaves the whole array unchanged.
- Port 1 write accepted, `reset_n` dropped the next cycle → no `resp_valid`, array equals `input_data` after reset.
- Unaligned read addr 0x0E → same data as 0x0C.
